dp_pipe_ctrl: RTL

- Sequencing and precision-mode controller for the multi-precision dot-product pipeline.
- Tracks operation validity and precision tag through STAGES register stages, with valid/ready at both ends.
- Drives per-stage enables: stage_en for sign/exp/low-mantissa registers, stage_hi_en for the high-mantissa half. The high half is enabled only for full-precision ops, which saves power in low-precision mode.
- Drains the pipeline before any precision change and idles it after inactivity.

---
 rtl/dp_pipe_ctrl_if.sv | 22 ++
 rtl/dp_pipe_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dp_pipe_ctrl_if.sv
// Request/result handshake bundle for the dot-product pipeline controller.
// Interface signal names follow the controller's port list.
interface dp_pipe_ctrl_if;
  logic in_valid;
  logic in_mode;
  logic in_ready;
  logic out_valid;
  logic out_mode;
  logic out_ready;

  // Requester and result-consumer side.
  modport master (
    output in_valid, in_mode, out_ready,
    input  in_ready, out_valid, out_mode
  );

  // Controller side.
  modport slave (
    input  in_valid, in_mode, out_ready,
    output in_ready, out_valid, out_mode
  );
endinterface

// File: rtl/dp_pipe_ctrl.sv
// Sequencing and precision-mode controller for the multi-precision
// dot-product pipeline. Tracks op validity and precision tag through STAGES
// register stages, drives per-stage load enables (low half always, high half
// only for full-precision ops), drains before a precision change and parks
// the pipeline in IDLE after a stretch of inactivity.
module dp_pipe_ctrl #(
  parameter int STAGES     = 4,
  parameter int SWITCH_CYC = 2,
  parameter int IDLE_CYC   = 8
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  dp_pipe_ctrl_if.slave     bus,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_hi_en,
  output logic              cur_mode,
  output logic              busy,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int SW = $clog2(SWITCH_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_CYC - 1);
  localparam logic [SW-1:0] SWITCH_LOAD = SW'(SWITCH_CYC - 1);

  state_t            r_state, w_state_nxt;
  logic [STAGES-1:0] r_v, w_v_nxt;
  logic [STAGES-1:0] r_m, w_m_nxt;
  logic [IW-1:0]     r_idle_cnt, w_idle_cnt_nxt;
  logic [SW-1:0]     r_sw_cnt, w_sw_cnt_nxt;
  logic              r_cur_mode, w_cur_mode_nxt;
  logic              r_pend_mode, w_pend_mode_nxt;
  logic              w_advance;
  logic              w_in_ready;
  logic              w_accept;

  // The whole pipeline moves unless the last stage holds a result nobody takes.
  // in_ready is gated by rst so nothing is offered while reset is asserted.
  assign w_advance  = ~r_v[STAGES-1] | bus.out_ready;
  assign w_in_ready = rst & w_advance & (r_state == ST_RUN) &
                      (bus.in_mode == r_cur_mode);
  assign w_accept   = bus.in_valid & w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v[STAGES-1];
  assign bus.out_mode  = r_m[STAGES-1];

  // A stage loads only when a real op moves into it; bubbles never toggle
  // the datapath, and the high half loads only for full-precision ops.
  assign stage_en    = {r_v[STAGES-2:0] & {(STAGES-1){w_advance}}, w_accept};
  assign stage_hi_en = {r_v[STAGES-2:0] & r_m[STAGES-2:0] & {(STAGES-1){w_advance}},
                        w_accept & bus.in_mode};

  assign cur_mode = r_cur_mode;
  assign busy     = (|r_v) | (r_state == ST_DRAIN) | (r_state == ST_SWITCH);
  assign state_o  = r_state;

  // Next contents of the valid/tag shift register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    w_v_nxt = r_v;
    w_m_nxt = r_m;
    if (w_advance) begin
      w_v_nxt = {r_v[STAGES-2:0], w_accept};
      w_m_nxt = {r_m[STAGES-2:0], bus.in_mode};
    end
  end

  // Valid/tag shift register; an async reset discards every in-flight op.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_v <= '0;
      // NOTE: the tag bits are reset too, so out_mode reads 0 straight out of
      // reset instead of a stale precision tag.
      r_m <= '0;
    end else begin
      r_v <= w_v_nxt;
      r_m <= w_m_nxt;
    end
  end

  // Next-state logic: precision-switch sequencing, idle detection and wake-up.
  always_comb begin
    w_state_nxt     = r_state;
    w_idle_cnt_nxt  = r_idle_cnt;
    w_sw_cnt_nxt    = r_sw_cnt;
    w_pend_mode_nxt = r_pend_mode;
    w_cur_mode_nxt  = r_cur_mode;
    unique case (r_state)
      ST_RUN: begin
        if (bus.in_valid && (bus.in_mode != r_cur_mode)) begin
          // A request of the other precision: stop accepting and drain.
          w_state_nxt     = ST_DRAIN;
          w_pend_mode_nxt = bus.in_mode;
          w_idle_cnt_nxt  = '0;
        end else if (!(|r_v) && !bus.in_valid) begin
          if (r_idle_cnt == IDLE_LAST) begin
            w_state_nxt    = ST_IDLE;
            w_idle_cnt_nxt = '0;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + IW'(1);
          end
        end else begin
          w_idle_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        // Leave once the pipeline will be empty after this edge.
        if (!(|w_v_nxt)) begin
          w_state_nxt  = ST_SWITCH;
          w_sw_cnt_nxt = SWITCH_LOAD;
        end
      end
      ST_SWITCH: begin
        w_cur_mode_nxt = r_pend_mode;
        if (r_sw_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_sw_cnt_nxt = r_sw_cnt - SW'(1);
        end
      end
      ST_IDLE: begin
        // One wake cycle; any mode mismatch is resolved from RUN.
        if (bus.in_valid) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters and precision registers that travel with the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt  <= '0;
      r_sw_cnt    <= '0;
      r_cur_mode  <= 1'b0;
      r_pend_mode <= 1'b0;
    end else begin
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_sw_cnt    <= w_sw_cnt_nxt;
      r_cur_mode  <= w_cur_mode_nxt;
      r_pend_mode <= w_pend_mode_nxt;
    end
  end

endmodule
